ps2_host_tx: RTL and testbench

// - Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard.
// - Complements the ps2ctrlr receiver and shares the PS2_CLK/PS2_DAT pins with it through open-drain enables.
// - The CPU-side register logic in the computer_8bit top level issues a byte with a valid/ready handshake.
// - The block reports done, ack_err or timeout for each byte.

---
 rtl/ps2_host_tx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter; sends one command byte over open-drain CLK/DAT enables.
// Latency: accept -> INHIBIT_CYCLES of CLK low -> 1-cycle request -> device-clocked frame -> status pulse.
// Backpressure: tx_ready only in IDLE, tx_valid while busy is ignored. Optional CLK glitch filter: PS2_TX_FILTER_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILT_LEN       = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic [8:0]    shift, shift_n;
  logic [3:0]    bit_cnt, bit_n;
  logic          ack_ok, ok_n;
  logic          clk_oe_n, dat_oe_n;

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic clk_lvl, clk_lvl_d, fall;
  logic tmo_run, tmo_hit;

  // Two-flop synchronisers; reset to the idle (pulled-up) level so reset creates no false fall
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

`ifdef PS2_TX_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] filt_cnt;
  logic          clk_f;

  // Filtered CLK follows the synced level only after FILT_LEN consecutive differing samples
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_f    <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_f) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      clk_f    <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign clk_lvl = clk_f;
`else
  assign clk_lvl = clk_s2;
`endif

  // Delayed CLK level for falling-edge detection
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) clk_lvl_d <= 1'b1;
    else       clk_lvl_d <= clk_lvl;
  end

  assign fall     = clk_lvl_d & ~clk_lvl;
  assign tmo_run  = (state == S_XFER) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign tmo_hit  = tmo_run && (tmo_cnt == TW'(TIMEOUT_CYCLES));
  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // State and datapath registers; line enables are registered so no input reaches the pins combinationally
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      inh_cnt    <= '0;
      tmo_cnt    <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      ack_ok     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state      <= state_n;
      inh_cnt    <= inh_n;
      tmo_cnt    <= tmo_n;
      shift      <= shift_n;
      bit_cnt    <= bit_n;
      ack_ok     <= ok_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
    end
  end

  // Next-state, next-datapath and status pulses; timeout wins over any fall or completion
  always_comb begin
    state_n  = state;
    inh_n    = inh_cnt;
    tmo_n    = tmo_cnt;
    shift_n  = shift;
    bit_n    = bit_cnt;
    ok_n     = ack_ok;
    clk_oe_n = ps2_clk_oe;
    dat_oe_n = ps2_dat_oe;
    done     = 1'b0;
    ack_err  = 1'b0;
    timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (tx_valid) begin
          shift_n  = {~^tx_data, tx_data};
          inh_n    = '0;
          clk_oe_n = 1'b1;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
          dat_oe_n = 1'b1;
          state_n  = S_REQ;
        end else begin
          inh_n = inh_cnt + 1'b1;
        end
      end
      S_REQ: begin
        clk_oe_n = 1'b0;
        tmo_n    = '0;
        bit_n    = '0;
        state_n  = S_XFER;
      end
      S_XFER, S_ACK, S_WAIT_IDLE: begin
        tmo_n = tmo_cnt + 1'b1;
        if (tmo_hit) begin
          timeout  = 1'b1;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          state_n  = S_IDLE;
        end else if (state == S_XFER) begin
          if (fall) begin
            if (bit_cnt == 4'd9) begin
              dat_oe_n = 1'b0;
              state_n  = S_ACK;
            end else begin
              dat_oe_n = ~shift[0];
              shift_n  = {1'b0, shift[8:1]};
              bit_n    = bit_cnt + 1'b1;
            end
          end
        end else if (state == S_ACK) begin
          if (fall) begin
            ok_n    = ~dat_s2;
            state_n = S_WAIT_IDLE;
          end
        end else begin
          if (clk_s2 && dat_s2) begin
            done    = ack_ok;
            ack_err = ~ack_ok;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Device clocks with a 40-cycle period; frames are sampled at the end of each low phase.
// Build with PS2_TX_FILTER_EN defined to add the CLK glitch case.
module tb_ps2_host_tx;

  localparam int HALF = 20;
  localparam int TMO  = 3000;
  localparam int INH  = 5000;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, ack_err, timeout;
  logic       PS2_CLK, PS2_DAT, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_err = 0, n_tmo = 0;

  assign PS2_CLK = dev_clk & ~ps2_clk_oe;
  assign PS2_DAT = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILT_LEN(8)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err),
    .timeout   (timeout),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Count status cycles; each pulse must add exactly one
  always @(negedge CLOCK_50) begin
    if (done)    n_done++;
    if (ack_err) n_err++;
    if (timeout) n_tmo++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge CLOCK_50);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  // Device: wait for the host request, then clock nfall falls; bits[0]=start, [8:1]=data, [9]=parity, [10]=stop
  task automatic dev_xfer(input bit ack, input int nfall, input bit glitch, output logic [10:0] bits);
    bit seen;
    bits = '0;
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge CLOCK_50);
      if (!ps2_clk_oe && ps2_dat_oe) seen = 1'b1;
    end
    chk("req_seen", seen, 1);
    if (!seen) return;
    repeat (HALF) @(negedge CLOCK_50);
    bits[0] = PS2_DAT;
    for (int i = 1; i <= nfall; i++) begin
      dev_clk = 1'b0;
      if (i == 11 && ack) dev_dat = 1'b0;
      if (i == nfall && nfall < 11) return;
      repeat (HALF) @(negedge CLOCK_50);
      if (i <= 10) bits[i] = PS2_DAT;
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      if (i < 11) begin
        if (glitch && i == 3) begin
          repeat (5) @(negedge CLOCK_50);
          dev_clk = 1'b0;
          repeat (3) @(negedge CLOCK_50);
          dev_clk = 1'b1;
          repeat (HALF - 8) @(negedge CLOCK_50);
        end else begin
          repeat (HALF) @(negedge CLOCK_50);
        end
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 200 && !idle; k++) begin
      @(negedge CLOCK_50);
      if (!busy) idle = 1'b1;
    end
    chk(tag, idle, 1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge CLOCK_50);
      if (done) seen = 1'b1;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    logic [10:0] bits;
    int c, r, k, bd, be, bt;

    reset = 1'b1; dev_clk = 1'b1; dev_dat = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("rst_status", {done, ack_err, timeout}, 3'b000);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    // 0xED with full inhibit/request timing
    send(8'hED);
    chk("ed_busy", busy, 1);
    chk("ed_tx_ready", tx_ready, 0);
    c = 0;
    while (ps2_clk_oe && !ps2_dat_oe && c < 10000) begin c++; @(negedge CLOCK_50); end
    chk("ed_inhibit_len", c, INH);
    r = 0;
    while (ps2_clk_oe && ps2_dat_oe && r < 10) begin r++; @(negedge CLOCK_50); end
    chk("ed_req_len", r, 1);
    dev_xfer(1'b1, 11, 1'b0, bits);
    chk("ed_frame", bits, {1'b1, 1'b1, 8'hED, 1'b0});
    wait_idle("ed_idle");
    chk("ed_done_cnt", n_done, 1);
    chk("ed_err_cnt", {n_err[15:0], n_tmo[15:0]}, 0);

    // 0xF4: parity 0, tx_ready back the cycle after done
    send(8'hF4);
    dev_xfer(1'b1, 11, 1'b0, bits);
    chk("f4_frame", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
    wait_done("f4_done_seen");
    chk("f4_ready_at_done", tx_ready, 0);
    @(negedge CLOCK_50);
    chk("f4_ready_after", tx_ready, 1);
    chk("f4_done_cnt", n_done, 2);

    // Withheld ACK
    send(8'h12);
    dev_xfer(1'b0, 11, 1'b0, bits);
    chk("nack_frame", bits, {1'b1, 1'b1, 8'h12, 1'b0});
    wait_idle("nack_idle");
    chk("nack_err_cnt", n_err, 1);
    chk("nack_done_cnt", n_done, 2);
    chk("nack_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);

    // No device clock: timeout TMO cycles after leaving the request
    send(8'h3C);
    k = 0;
    while (!(!ps2_clk_oe && ps2_dat_oe) && k < 10000) begin k++; @(negedge CLOCK_50); end
    chk("tmo_req_seen", (!ps2_clk_oe && ps2_dat_oe), 1);
    k = 0;
    while (!timeout && k < 5000) begin @(negedge CLOCK_50); k++; end
    chk("tmo_latency", k, TMO);
    @(negedge CLOCK_50);
    chk("tmo_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("tmo_ready", tx_ready, 1);
    chk("tmo_cnt", n_tmo, 1);

    // Reset at the 5th data fall (bit4 of 0xED is 0, so DAT is being driven)
    bd = n_done; be = n_err; bt = n_tmo;
    send(8'hED);
    dev_xfer(1'b1, 5, 1'b0, bits);
    repeat (5) @(negedge CLOCK_50);
    chk("abort_pre_dat_oe", ps2_dat_oe, 1);
    reset = 1'b1;
    #1;
    chk("abort_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    repeat (3) @(negedge CLOCK_50);
    dev_clk = 1'b1; dev_dat = 1'b1;
    reset = 1'b0;
    repeat (50) @(negedge CLOCK_50);
    chk("abort_ready", tx_ready, 1);
    chk("abort_no_status", {n_done - bd, n_err - be, n_tmo - bt}, 0);

    // tx_valid held: 0x55 sent, 0xAA accepted right after done
    @(negedge CLOCK_50);
    tx_data = 8'h55; tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_data = 8'hAA;
    chk("hold_busy", busy, 1);
    dev_xfer(1'b1, 11, 1'b0, bits);
    chk("hold_frame55", bits, {1'b1, 1'b1, 8'h55, 1'b0});
    wait_done("hold_done55");
    chk("hold_ready_at_done", tx_ready, 0);
    @(negedge CLOCK_50);
    chk("hold_ready_after", tx_ready, 1);
    @(negedge CLOCK_50);
    chk("hold_aa_accepted", busy, 1);
    tx_valid = 1'b0;
    dev_xfer(1'b1, 11, 1'b0, bits);
    chk("hold_frameAA", bits, {1'b1, 1'b1, 8'hAA, 1'b0});
    wait_idle("hold_idleAA");
    chk("hold_done_cnt", n_done - bd, 2);

`ifdef PS2_TX_FILTER_EN
    // 3-cycle CLK glitch during the frame must not add a bit
    bd = n_done;
    send(8'hED);
    dev_xfer(1'b1, 11, 1'b1, bits);
    chk("glitch_frame", bits, {1'b1, 1'b1, 8'hED, 1'b0});
    wait_idle("glitch_idle");
    chk("glitch_done_cnt", n_done - bd, 1);
`endif

    chk("final_err_tmo", {n_err[15:0], n_tmo[15:0]}, {16'd1, 16'd1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
